mips_mc_control: RTL and testbench

Multi-cycle controller for the MIPS core. It replaces the single-cycle opcode decoder with a state machine that sequences each instruction over 3–5 cycles and shares one ALU and one memory port. It adds a ready/request handshake for variable-latency memory, a memory-timeout trap, and a retired-instruction counter. It drives the shared datapath's register enables and multiplexer selects (PC, IR, regfile, ALU, memory).

---
 rtl/mips_mc_control.sv | 203 ++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS controller: sequences each instruction through a shared ALU and
// memory port, with a ready/request memory handshake, timeout trap and retire counter.
module mips_mc_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_en,
  output logic [1:0]           pc_source,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic                 mem_to_reg,
  output logic                 is_jal,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           ula_operation,
  output logic [3:0]           state,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JR       = 4'd10,
    S_IMMEXEC  = 4'd11,
    S_IMMWB    = 4'd12,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Counter only needs to reach MEM_TIMEOUT-1; the trap fires before it could wrap.
  localparam int             WCW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int             LIM      = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(LIM);
  localparam bit             TO_EN    = (MEM_TIMEOUT > 0);

  state_t         cur, nxt;
  logic [WCW-1:0] wait_cnt;
  logic           mem_state;
  logic           timeout;

  assign mem_state = (cur == S_FETCH) || (cur == S_MEMREAD) || (cur == S_MEMWRITE);
  assign timeout   = TO_EN && mem_state && !mem_ready && (wait_cnt == WAIT_LIM);
  assign state     = cur;
  assign error     = (cur == S_ERROR);

  always_ff @(posedge clock) begin
    if (reset) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      cur <= nxt;
      if ((nxt != cur) || mem_ready || !mem_state) wait_cnt <= '0;
      else                                         wait_cnt <= wait_cnt + 1'b1;
      // An instruction retires on its return to FETCH; fetch stalls do not count.
      if ((nxt == S_FETCH) && (cur != S_FETCH)) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:    if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:       nxt = (funct == FN_JR) ? S_JR : S_EXEC;
          OP_LW, OP_SW:   nxt = S_MEMADDR;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_J, OP_JAL:   nxt = S_JUMP;
          OP_ADDI:        nxt = S_IMMEXEC;
          default:        nxt = S_ERROR;
        endcase
      end
      S_MEMADDR:  nxt = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
      S_EXEC:     nxt = S_RWB;
      S_RWB:      nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_JUMP:     nxt = S_FETCH;
      S_JR:       nxt = S_FETCH;
      S_IMMEXEC:  nxt = S_IMMWB;
      S_IMMWB:    nxt = S_FETCH;
      S_ERROR:    nxt = S_ERROR;
      default:    nxt = S_ERROR;
    endcase
    if (timeout) nxt = S_ERROR;
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_source     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 1'b0;
    is_jal        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ula_operation = 3'b000;
    case (cur)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a     = 1'b1;
        ula_operation = 3'b010;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        ula_operation = 3'b001;
        pc_source     = 2'b01;
        pc_en         = (opcode == OP_BEQ) ? zero : !zero;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
        // PC already advanced in FETCH, so the link value is the live PC.
        if (opcode == OP_JAL) begin
          reg_write = 1'b1;
          reg_dst   = 2'b10;
          is_jal    = 1'b1;
        end
      end
      S_JR: begin
        pc_source = 2'b11;
        pc_en     = 1'b1;
      end
      S_IMMEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_IMMWB:    reg_write = 1'b1;
      default: ;
    endcase
    // Nothing architectural may be written while reset aborts the instruction.
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: per-instruction state paths and control words from a
// path table, checked on a default instance and a MEM_TIMEOUT=4 / CNT_WIDTH=4 instance.
module tb_mips_mc_control;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5,
                         EX = 4'd6, RWB = 4'd7, BR = 4'd8, J = 4'd9, JR = 4'd10,
                         IE = 4'd11, IWB = 4'd12, ERR = 4'd15;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03, OP_ADDI = 6'h08;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic a_mem_req, a_mem_write, a_i_or_d, a_ir_write, a_pc_en, a_reg_write;
  logic a_mem_to_reg, a_is_jal, a_alu_src_a, a_error;
  logic [1:0] a_pc_source, a_reg_dst, a_alu_src_b;
  logic [2:0] a_ula;
  logic [3:0] a_state;
  logic [31:0] a_retired;
  logic b_mem_req, b_mem_write, b_i_or_d, b_ir_write, b_pc_en, b_reg_write;
  logic b_mem_to_reg, b_is_jal, b_alu_src_a, b_error;
  logic [1:0] b_pc_source, b_reg_dst, b_alu_src_b;
  logic [2:0] b_ula;
  logic [3:0] b_state;
  logic [3:0] b_retired;
  logic [17:0] a_ctl, b_ctl;

  int checks = 0;
  int errors = 0;
  int ret_a = 0;
  int ret_b = 0;
  logic [5:0] ops [0:8];

  always #5 clock = ~clock;

  mips_mc_control u_a (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(a_mem_req), .mem_write(a_mem_write),
    .i_or_d(a_i_or_d), .ir_write(a_ir_write), .pc_en(a_pc_en), .pc_source(a_pc_source),
    .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .is_jal(a_is_jal), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .ula_operation(a_ula), .state(a_state), .error(a_error), .retired(a_retired)
  );

  mips_mc_control #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) u_b (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(b_mem_req), .mem_write(b_mem_write),
    .i_or_d(b_i_or_d), .ir_write(b_ir_write), .pc_en(b_pc_en), .pc_source(b_pc_source),
    .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .is_jal(b_is_jal), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .ula_operation(b_ula), .state(b_state), .error(b_error), .retired(b_retired)
  );

  assign a_ctl = {a_mem_req, a_mem_write, a_i_or_d, a_ir_write, a_pc_en, a_pc_source,
                  a_reg_write, a_reg_dst, a_mem_to_reg, a_is_jal, a_alu_src_a,
                  a_alu_src_b, a_ula};
  assign b_ctl = {b_mem_req, b_mem_write, b_i_or_d, b_ir_write, b_pc_en, b_pc_source,
                  b_reg_write, b_reg_dst, b_mem_to_reg, b_is_jal, b_alu_src_a,
                  b_alu_src_b, b_ula};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rnd();
    return $urandom_range(1) != 0;
  endfunction

  // Control word each state must present, straight from the state table.
  function automatic logic [17:0] exp_ctl(input logic [3:0] s, input logic rdy);
    logic mreq, mw, iod, irw, pce, rw, m2r, jal, asa;
    logic [1:0] pcs, rd, asb;
    logic [2:0] op3;
    mreq = 0; mw = 0; iod = 0; irw = 0; pce = 0; rw = 0; m2r = 0; jal = 0; asa = 0;
    pcs = 0; rd = 0; asb = 0; op3 = 0;
    case (s)
      F:       begin mreq = 1; asb = 2'b01; irw = rdy; pce = rdy; end
      D:       asb = 2'b11;
      MA, IE:  begin asa = 1; asb = 2'b10; end
      MR:      begin mreq = 1; iod = 1; end
      MWB:     begin rw = 1; m2r = 1; end
      MW:      begin mreq = 1; mw = 1; iod = 1; end
      EX:      begin asa = 1; op3 = 3'b010; end
      RWB:     begin rw = 1; rd = 2'b01; end
      BR:      begin asa = 1; op3 = 3'b001; pcs = 2'b01;
                     pce = (opcode == OP_BEQ) ? zero : !zero; end
      J:       begin pcs = 2'b10; pce = 1;
                     if (opcode == OP_JAL) begin rw = 1; rd = 2'b10; jal = 1; end end
      JR:      begin pcs = 2'b11; pce = 1; end
      IWB:     rw = 1;
      default: ;
    endcase
    return {mreq, mw, iod, irw, pce, pcs, rw, rd, m2r, jal, asa, asb, op3};
  endfunction

  // One clock cycle: drive mem_ready, check both instances mid-cycle, advance.
  task automatic step(input logic rdy, input logic [3:0] s);
    mem_ready = rdy;
    @(negedge clock);
    chk("state_a", 32'(a_state), 32'(s));
    chk("state_b", 32'(b_state), 32'(s));
    chk("ctl_a", 32'(a_ctl), 32'(exp_ctl(s, rdy)));
    chk("ctl_b", 32'(b_ctl), 32'(exp_ctl(s, rdy)));
    chk("error_a", 32'(a_error), 32'(s == ERR));
    chk("retired_a", a_retired, 32'(ret_a));
    chk("retired_b", 32'(b_retired), 32'(ret_b % 16));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("rst_enables_a", 32'({a_pc_en, a_ir_write, a_reg_write, a_mem_write}), 32'd0);
      chk("rst_enables_b", 32'({b_pc_en, b_ir_write, b_reg_write, b_mem_write}), 32'd0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    ret_a = 0;
    ret_b = 0;
  endtask

  // Reference path of one instruction: wf fetch stalls, wm stalls in its memory state.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm);
    opcode = op; funct = fn; zero = z;
    repeat (wf) step(1'b0, F);
    step(1'b1, F);
    step(rnd(), D);
    case (op)
      OP_R:
        if (fn == FN_JR) step(rnd(), JR);
        else begin step(rnd(), EX); step(rnd(), RWB); end
      OP_LW: begin
        step(rnd(), MA);
        repeat (wm) step(1'b0, MR);
        step(1'b1, MR);
        step(rnd(), MWB);
      end
      OP_SW: begin
        step(rnd(), MA);
        repeat (wm) step(1'b0, MW);
        step(1'b1, MW);
      end
      OP_BEQ, OP_BNE: step(rnd(), BR);
      OP_J, OP_JAL:   step(rnd(), J);
      OP_ADDI: begin step(rnd(), IE); step(rnd(), IWB); end
      default: begin
        repeat (3) step(rnd(), ERR);
        return;
      end
    endcase
    ret_a++;
    ret_b++;
  endtask

  initial begin
    ops[0] = OP_R; ops[1] = OP_R; ops[2] = OP_LW; ops[3] = OP_SW; ops[4] = OP_BEQ;
    ops[5] = OP_BNE; ops[6] = OP_J; ops[7] = OP_JAL; ops[8] = OP_ADDI;

    do_reset();
    run_instr(OP_R, FN_ADD, 1'b0, 0, 0);
    run_instr(OP_LW, 6'h00, 1'b0, 0, 3);
    run_instr(OP_BEQ, 6'h00, 1'b1, 0, 0);
    run_instr(OP_BNE, 6'h00, 1'b1, 0, 0);
    run_instr(OP_BEQ, 6'h00, 1'b0, 1, 0);
    run_instr(OP_BNE, 6'h00, 1'b0, 0, 0);
    run_instr(OP_JAL, 6'h00, 1'b0, 0, 0);
    run_instr(OP_R, FN_JR, 1'b0, 0, 0);
    run_instr(OP_SW, 6'h00, 1'b0, 2, 3);
    run_instr(OP_ADDI, 6'h11, 1'b0, 3, 0);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(8)];
      fn = ($urandom_range(3) == 0) ? FN_JR : 6'($urandom_range(63));
      run_instr(op, fn, rnd(), $urandom_range(3), $urandom_range(3));
    end

    // 17 jumps: the 4-bit counter wraps to 1.
    do_reset();
    repeat (17) run_instr(OP_J, 6'h00, 1'b0, 0, 0);
    @(negedge clock);
    chk("wrap_b", 32'(b_retired), 32'd1);
    chk("nowrap_a", a_retired, 32'd17);
    @(posedge clock);
    #1;

    // Reset while a store waits on memory, then a clean instruction with 3 fetch stalls.
    do_reset();
    opcode = OP_SW;
    step(1'b1, F);
    step(rnd(), D);
    step(rnd(), MA);
    step(1'b0, MW);
    step(1'b0, MW);
    do_reset();
    run_instr(OP_R, FN_ADD, 1'b0, 3, 0);

    run_instr(6'h3f, 6'h00, 1'b0, 0, 0);
    do_reset();

    // Fetch never ready: instance b traps after 4 cycles, instance a after 16.
    mem_ready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clock);
      chk("to_state_a", 32'(a_state), (i < 16) ? 32'(F) : 32'(ERR));
      chk("to_state_b", 32'(b_state), (i < 4) ? 32'(F) : 32'(ERR));
      chk("to_error_b", 32'(b_error), 32'(i >= 4));
      chk("to_error_a", 32'(a_error), 32'(i >= 16));
      @(posedge clock);
      #1;
    end
    repeat (3) begin
      mem_ready = 1'b1;
      @(negedge clock);
      chk("err_hold_a", 32'({a_state, a_error, a_mem_req, a_pc_en}), 32'({ERR, 3'b100}));
      chk("err_hold_b", 32'({b_state, b_error, b_mem_req, b_pc_en}), 32'({ERR, 3'b100}));
      @(posedge clock);
      #1;
    end
    do_reset();
    run_instr(OP_R, FN_ADD, 1'b0, 0, 0);
    run_instr(OP_LW, 6'h00, 1'b0, 1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
